// File: rtl/i2c_mcp4726_resp_if.sv
// Pad-side I2C lines plus the decoded DAC outputs of the MCP4726 responder.
// slave = responder; master = pad/bus side that drives SCL/SDA and consumes the DAC outputs.
interface i2c_mcp4726_resp_if;
  logic        SCL_i;
  logic        SDA_i;
  logic        SDA_OE_o;
  logic [11:0] DAC_CODEs_o;
  logic [1:0]  PD_o;
  logic        UPDATE_o;
  logic        BUSY_o;

  modport slave  (input SCL_i, SDA_i,
                  output SDA_OE_o, DAC_CODEs_o, PD_o, UPDATE_o, BUSY_o);
  modport master (output SCL_i, SDA_i,
                  input SDA_OE_o, DAC_CODEs_o, PD_o, UPDATE_o, BUSY_o);
endinterface

// File: rtl/i2c_mcp4726_resp.sv
// I2C target emulating an MCP4726 DAC (fast write + 3-byte read); general call under MCP4726_GCALL_EN.
// Latency: pads see 2 CK sync + C_FILT_LEN CK filter; DAC/PD/UPDATE change 1 CK after the final ACK rising SCL.
// Backpressure: none; the bus master paces every bit, the target only ACKs or NACKs.
module i2c_mcp4726_resp #(
  parameter logic [6:0]  C_DEV_ADR  = 7'h60,
  parameter int          C_FILT_LEN = 3,
  parameter logic [11:0] C_DAC_INIT = 12'h000
) (
  input logic               CK_i,
  input logic               ARST_i,
  i2c_mcp4726_resp_if.slave bus
);

  localparam logic [3:0] FILT_MAX = 4'(C_FILT_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ACK_A, ST_WR_BYTE, ST_WR_ACK, ST_RD_BYTE, ST_RD_ACK, ST_IGNORE
  } state_t;

  // Bit 0 carries SCL, bit 1 carries SDA through sync and filter.
  logic [1:0]      sync1, sync2, filt, filt_q;
  logic [1:0][3:0] fcnt;

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_q <= 2'b11;
      fcnt   <= '0;
    end else begin
      sync1  <= {bus.SDA_i, bus.SCL_i};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= 4'd0;
        end else if (fcnt[i] == FILT_MAX) begin
          filt[i] <= sync2[i];
          fcnt[i] <= 4'd0;
        end else begin
          fcnt[i] <= fcnt[i] + 4'd1;
        end
      end
    end
  end

  logic fsda, rscl, fscln, start, stop;
  assign fsda  = filt[1];
  assign rscl  = filt[0] & ~filt_q[0];
  assign fscln = ~filt[0] & filt_q[0];
  assign start = filt[0] & filt_q[0] & filt_q[1] & ~filt[1];
  assign stop  = filt[0] & filt_q[0] & ~filt_q[1] & filt[1];

  state_t      state, state_nxt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg, rd_dat, rd_sel, lo_byte;
  logic        byte_idx, idx_nxt;
  logic [1:0]  rd_idx, rd_idx_nxt;
  logic [3:0]  hi_nib;
  logic [1:0]  pd_pend;
  logic [11:0] dac;
  logic [1:0]  pd;
  logic        upd, busy, sda_oe;
  logic        shift_en, cnt_clr, snap_en, hi_en, lo_en, commit, oe_nxt;
`ifdef MCP4726_GCALL_EN
  logic        gc_q, gc_rst_q, gc_ld, gc_cmd_en, gc_commit;
`endif

  logic [7:0] byte_in;
  logic       last_bit;
  assign byte_in  = {shreg[6:0], fsda};
  assign last_bit = rscl && (bit_cnt == 3'd7);

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // START/STOP pre-empt everything; oe_nxt is the SDA level to present from the next falling SCL.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = byte_idx;
    rd_idx_nxt = rd_idx;
    shift_en   = 1'b0;
    cnt_clr    = 1'b0;
    snap_en    = 1'b0;
    hi_en      = 1'b0;
    lo_en      = 1'b0;
    commit     = 1'b0;
    oe_nxt     = 1'b0;
`ifdef MCP4726_GCALL_EN
    gc_ld      = 1'b0;
    gc_cmd_en  = 1'b0;
    gc_commit  = 1'b0;
`endif
    if (start) begin
      state_nxt = ST_ADDR;
      cnt_clr   = 1'b1;
    end else if (stop) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_IGNORE: begin
        end
        ST_ADDR: begin
          shift_en = rscl;
          if (last_bit) begin
            if (byte_in[7:1] == C_DEV_ADR) state_nxt = ST_ACK_A;
`ifdef MCP4726_GCALL_EN
            else if (byte_in == 8'h00)     state_nxt = ST_ACK_A;
`endif
            else                           state_nxt = ST_IGNORE;
          end
        end
        ST_ACK_A: begin
          oe_nxt = 1'b1;
          if (rscl) begin
            cnt_clr = 1'b1;
`ifdef MCP4726_GCALL_EN
            gc_ld   = 1'b1;
`endif
            if (shreg[0]) begin
              state_nxt  = ST_RD_BYTE;
              rd_idx_nxt = 2'd0;
              snap_en    = 1'b1;
            end else begin
              state_nxt = ST_WR_BYTE;
              idx_nxt   = 1'b0;
            end
          end
        end
        ST_WR_BYTE: begin
          shift_en = rscl;
          if (last_bit) begin
            state_nxt = ST_WR_ACK;
`ifdef MCP4726_GCALL_EN
            if (gc_q) begin
              gc_cmd_en = 1'b1;
              if (byte_in != 8'h06 && byte_in != 8'h09) state_nxt = ST_IGNORE;
            end else
`endif
            if (!byte_idx) begin
              hi_en = (byte_in[7:6] == 2'b00);
              if (byte_in[7:6] != 2'b00) state_nxt = ST_IGNORE;
            end else begin
              lo_en = 1'b1;
            end
          end
        end
        ST_WR_ACK: begin
          oe_nxt = 1'b1;
          if (rscl) begin
            cnt_clr   = 1'b1;
            state_nxt = ST_WR_BYTE;
            idx_nxt   = ~byte_idx;
`ifdef MCP4726_GCALL_EN
            if (gc_q) begin
              gc_commit = 1'b1;
              state_nxt = ST_IGNORE;
            end else
`endif
            commit = byte_idx;
          end
        end
        ST_RD_BYTE: begin
          oe_nxt = ~rd_dat[~bit_cnt];
          if (last_bit) state_nxt = ST_RD_ACK;
        end
        ST_RD_ACK: begin
          if (rscl) begin
            cnt_clr = 1'b1;
            if (!fsda) begin
              state_nxt  = ST_RD_BYTE;
              rd_idx_nxt = (rd_idx == 2'd2) ? 2'd0 : rd_idx + 2'd1;
              snap_en    = 1'b1;
            end else begin
              state_nxt = ST_IGNORE;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    case (rd_idx_nxt)
      2'd1:    rd_sel = dac[11:4];
      2'd2:    rd_sel = {dac[3:0], 4'h0};
      default: rd_sel = {5'b11000, pd, 1'b0};
    endcase
  end

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      byte_idx <= 1'b0;
      rd_idx   <= 2'd0;
      rd_dat   <= 8'h00;
      hi_nib   <= 4'h0;
      pd_pend  <= 2'b00;
      lo_byte  <= 8'h00;
      dac      <= C_DAC_INIT;
      pd       <= 2'b00;
      upd      <= 1'b0;
      busy     <= 1'b0;
      sda_oe   <= 1'b0;
`ifdef MCP4726_GCALL_EN
      gc_q     <= 1'b0;
      gc_rst_q <= 1'b0;
`endif
    end else begin
      upd      <= 1'b0;
      byte_idx <= idx_nxt;
      rd_idx   <= rd_idx_nxt;
      if (start)     busy <= 1'b1;
      else if (stop) busy <= 1'b0;
      if (start || stop) sda_oe <= 1'b0;
      else if (fscln)    sda_oe <= oe_nxt;
      if (cnt_clr)   bit_cnt <= 3'd0;
      else if (rscl) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shreg  <= byte_in;
      if (snap_en)  rd_dat <= rd_sel;
      if (hi_en) begin
        pd_pend <= byte_in[5:4];
        hi_nib  <= byte_in[3:0];
      end
      if (lo_en) lo_byte <= byte_in;
`ifdef MCP4726_GCALL_EN
      if (gc_ld)     gc_q     <= (shreg == 8'h00);
      if (gc_cmd_en) gc_rst_q <= (byte_in == 8'h06);
`endif
      if (commit) begin
        dac <= {hi_nib, lo_byte};
        pd  <= pd_pend;
        upd <= 1'b1;
      end
`ifdef MCP4726_GCALL_EN
      else if (gc_commit) begin
        if (gc_rst_q) dac <= C_DAC_INIT;
        pd  <= 2'b00;
        upd <= 1'b1;
      end
`endif
    end
  end

  assign bus.SDA_OE_o    = sda_oe;
  assign bus.DAC_CODEs_o = dac;
  assign bus.PD_o        = pd;
  assign bus.UPDATE_o    = upd;
  assign bus.BUSY_o      = busy;

endmodule

// File: tb/tb_i2c_mcp4726_resp.sv
// Directed bench for i2c_mcp4726_resp: bit-banged I2C master on an open-drain SDA model.
// Expectations under MCP4726_GCALL_EN follow the same macro as the RTL build.
module tb_i2c_mcp4726_resp;
  localparam int Q = 25;

`ifdef MCP4726_GCALL_EN
  localparam logic        GC_ACK = 1'b1;
  localparam logic [11:0] GC_DAC = 12'h000;
  localparam logic [1:0]  GC_PD  = 2'b00;
  localparam int          GC_UPD = 1;
`else
  localparam logic        GC_ACK = 1'b0;
  localparam logic [11:0] GC_DAC = 12'h345;
  localparam logic [1:0]  GC_PD  = 2'b10;
  localparam int          GC_UPD = 0;
`endif

  logic CK_i = 1'b0;
  logic ARST_i = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   upd_cnt = 0;
  bit   oe_seen = 1'b0;

  i2c_mcp4726_resp_if bus ();
  assign bus.SCL_i = m_scl;
  assign bus.SDA_i = m_sda & ~bus.SDA_OE_o;

  i2c_mcp4726_resp #(.C_DEV_ADR(7'h60), .C_FILT_LEN(3), .C_DAC_INIT(12'h000)) dut (
    .CK_i(CK_i), .ARST_i(ARST_i), .bus(bus));

  always #5 CK_i = ~CK_i;

  always @(posedge CK_i) begin
    if (bus.UPDATE_o) upd_cnt++;
    if (bus.SDA_OE_o) oe_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CK_i);
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; tick(Q); m_scl = 1'b1; tick(2 * Q); m_scl = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q);
    ack = ~bus.SDA_i;
    tick(Q); m_scl = 1'b0; tick(Q);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q);
      d[i] = bus.SDA_i;
      tick(Q); m_scl = 1'b0; tick(Q);
    end
    send_bit(nack);
  endtask

  task automatic test_reset;
    ARST_i = 1'b1; tick(5); ARST_i = 1'b0; tick(5);
    n_cmp++; if (bus.SDA_OE_o !== 1'b0) begin n_err++; $display("FAIL rst_oe: got %b want 0", bus.SDA_OE_o); end
    n_cmp++; if (bus.DAC_CODEs_o !== 12'h000) begin n_err++; $display("FAIL rst_dac: got %h want 000", bus.DAC_CODEs_o); end
    n_cmp++; if (bus.PD_o !== 2'b00) begin n_err++; $display("FAIL rst_pd: got %b want 00", bus.PD_o); end
    n_cmp++; if (bus.UPDATE_o !== 1'b0) begin n_err++; $display("FAIL rst_upd: got %b want 0", bus.UPDATE_o); end
    n_cmp++; if (bus.BUSY_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.BUSY_o); end
  endtask

  task automatic test_fast_write;
    logic ack;
    int   u0 = upd_cnt;
    i2c_start;
    n_cmp++; if (bus.BUSY_o !== 1'b1) begin n_err++; $display("FAIL fw_busy_start: got %b want 1", bus.BUSY_o); end
    write_byte(8'hC0, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL fw_ack_addr: got %b want 1", ack); end
    write_byte(8'h0A, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL fw_ack_hi: got %b want 1", ack); end
    n_cmp++; if (upd_cnt - u0 !== 0) begin n_err++; $display("FAIL fw_upd_early: got %0d want 0", upd_cnt - u0); end
    write_byte(8'hBC, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL fw_ack_lo: got %b want 1", ack); end
    n_cmp++; if (upd_cnt - u0 !== 1) begin n_err++; $display("FAIL fw_upd: got %0d want 1", upd_cnt - u0); end
    n_cmp++; if (bus.DAC_CODEs_o !== 12'hABC) begin n_err++; $display("FAIL fw_dac: got %h want abc", bus.DAC_CODEs_o); end
    n_cmp++; if (bus.PD_o !== 2'b00) begin n_err++; $display("FAIL fw_pd: got %b want 00", bus.PD_o); end
    i2c_stop; tick(10);
    n_cmp++; if (bus.BUSY_o !== 1'b0) begin n_err++; $display("FAIL fw_busy_stop: got %b want 0", bus.BUSY_o); end
  endtask

  task automatic test_read_back;
    logic       ack;
    logic [7:0] d;
    i2c_start;
    write_byte(8'hC1, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL rd_ack_addr: got %b want 1", ack); end
    read_byte(1'b0, d);
    n_cmp++; if (d !== 8'hC0) begin n_err++; $display("FAIL rd_b0: got %h want c0", d); end
    read_byte(1'b0, d);
    n_cmp++; if (d !== 8'hAB) begin n_err++; $display("FAIL rd_b1: got %h want ab", d); end
    read_byte(1'b1, d);
    n_cmp++; if (d !== 8'hC0) begin n_err++; $display("FAIL rd_b2: got %h want c0", d); end
    tick(10);
    n_cmp++; if (bus.SDA_OE_o !== 1'b0) begin n_err++; $display("FAIL rd_release: got %b want 0", bus.SDA_OE_o); end
    i2c_stop; tick(10);
  endtask

  task automatic test_wrong_addr;
    logic       ack;
    logic [7:0] seq [3] = '{8'hC4, 8'h0F, 8'hFF};
    int         u0 = upd_cnt;
    oe_seen = 1'b0;
    i2c_start;
    for (int i = 0; i < 3; i++) begin
      write_byte(seq[i], ack);
      n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL wa_ack%0d: got %b want 0", i, ack); end
    end
    i2c_stop; tick(10);
    n_cmp++; if (oe_seen !== 1'b0) begin n_err++; $display("FAIL wa_oe_seen: got %b want 0", oe_seen); end
    n_cmp++; if (bus.DAC_CODEs_o !== 12'hABC) begin n_err++; $display("FAIL wa_dac: got %h want abc", bus.DAC_CODEs_o); end
    n_cmp++; if (upd_cnt - u0 !== 0) begin n_err++; $display("FAIL wa_upd: got %0d want 0", upd_cnt - u0); end
  endtask

  task automatic test_abort_restart;
    logic ack;
    int   u0 = upd_cnt;
    i2c_start;
    write_byte(8'hC0, ack);
    write_byte(8'h01, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL ab_ack_hi: got %b want 1", ack); end
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    n_cmp++; if (bus.DAC_CODEs_o !== 12'hABC) begin n_err++; $display("FAIL ab_dac_partial: got %h want abc", bus.DAC_CODEs_o); end
    i2c_start;
    write_byte(8'hC0, ack);
    write_byte(8'h23, ack);
    write_byte(8'h45, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL ab_ack_lo: got %b want 1", ack); end
    i2c_stop; tick(10);
    n_cmp++; if (bus.DAC_CODEs_o !== 12'h345) begin n_err++; $display("FAIL ab_dac: got %h want 345", bus.DAC_CODEs_o); end
    n_cmp++; if (bus.PD_o !== 2'b10) begin n_err++; $display("FAIL ab_pd: got %b want 10", bus.PD_o); end
    n_cmp++; if (upd_cnt - u0 !== 1) begin n_err++; $display("FAIL ab_upd: got %0d want 1", upd_cnt - u0); end
  endtask

  task automatic test_gcall;
    logic ack;
    int   u0 = upd_cnt;
    i2c_start;
    write_byte(8'h00, ack);
    n_cmp++; if (ack !== GC_ACK) begin n_err++; $display("FAIL gc_ack_addr: got %b want %b", ack, GC_ACK); end
    write_byte(8'h06, ack);
    n_cmp++; if (ack !== GC_ACK) begin n_err++; $display("FAIL gc_ack_cmd: got %b want %b", ack, GC_ACK); end
    i2c_stop; tick(10);
    n_cmp++; if (bus.DAC_CODEs_o !== GC_DAC) begin n_err++; $display("FAIL gc_dac: got %h want %h", bus.DAC_CODEs_o, GC_DAC); end
    n_cmp++; if (bus.PD_o !== GC_PD) begin n_err++; $display("FAIL gc_pd: got %b want %b", bus.PD_o, GC_PD); end
    n_cmp++; if (upd_cnt - u0 !== GC_UPD) begin n_err++; $display("FAIL gc_upd: got %0d want %0d", upd_cnt - u0, GC_UPD); end
  endtask

  task automatic test_back_to_back;
    logic       ack;
    logic [7:0] d;
    logic [7:0] seq [5] = '{8'hC0, 8'h01, 8'h23, 8'h14, 8'h56};
    int         u0 = upd_cnt;
    i2c_start;
    for (int i = 0; i < 5; i++) begin
      write_byte(seq[i], ack);
      n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL bb_ack%0d: got %b want 1", i, ack); end
    end
    n_cmp++; if (upd_cnt - u0 !== 2) begin n_err++; $display("FAIL bb_upd: got %0d want 2", upd_cnt - u0); end
    n_cmp++; if (bus.DAC_CODEs_o !== 12'h456) begin n_err++; $display("FAIL bb_dac: got %h want 456", bus.DAC_CODEs_o); end
    n_cmp++; if (bus.PD_o !== 2'b01) begin n_err++; $display("FAIL bb_pd: got %b want 01", bus.PD_o); end
    i2c_start;
    write_byte(8'hC1, ack);
    read_byte(1'b1, d);
    n_cmp++; if (d !== 8'hC2) begin n_err++; $display("FAIL bb_rd_pd: got %h want c2", d); end
    i2c_stop; tick(10);
  endtask

  task automatic test_glitch_reset;
    logic       ack;
    logic [7:0] g = 8'h0D;
    int         u0 = upd_cnt;
    i2c_start;
    write_byte(8'hC0, ack);
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) begin
        m_sda = g[i]; tick(Q); m_scl = 1'b1; tick(Q);
        m_scl = 1'b0; tick(2); m_scl = 1'b1; tick(Q - 2);
        m_scl = 1'b0; tick(Q);
      end else begin
        send_bit(g[i]);
      end
    end
    m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q); ack = ~bus.SDA_i; tick(Q); m_scl = 1'b0; tick(Q);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL gl_ack: got %b want 1", ack); end
    write_byte(8'hEF, ack);
    i2c_stop; tick(10);
    n_cmp++; if (bus.DAC_CODEs_o !== 12'hDEF) begin n_err++; $display("FAIL gl_dac: got %h want def", bus.DAC_CODEs_o); end
    n_cmp++; if (upd_cnt - u0 !== 1) begin n_err++; $display("FAIL gl_upd: got %0d want 1", upd_cnt - u0); end
    i2c_start;
    for (int i = 7; i >= 0; i--) send_bit((i >= 6) ? 1'b1 : 1'b0);
    m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q);
    n_cmp++; if (bus.SDA_OE_o !== 1'b1) begin n_err++; $display("FAIL rs_oe_ack: got %b want 1", bus.SDA_OE_o); end
    ARST_i = 1'b1;
    #1;
    n_cmp++; if (bus.SDA_OE_o !== 1'b0) begin n_err++; $display("FAIL rs_oe_async: got %b want 0", bus.SDA_OE_o); end
    n_cmp++; if (bus.DAC_CODEs_o !== 12'h000) begin n_err++; $display("FAIL rs_dac: got %h want 000", bus.DAC_CODEs_o); end
    tick(3); ARST_i = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
    i2c_stop; tick(10);
    n_cmp++; if (bus.BUSY_o !== 1'b0) begin n_err++; $display("FAIL rs_busy: got %b want 0", bus.BUSY_o); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_fast_write;
    test_read_back;
    test_wrong_addr;
    test_abort_restart;
    test_gcall;
    test_back_to_back;
    test_glitch_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
